adc_clock_gen: RTL

- Programmable ADC sample-clock generator. Successor to the fixed toggle divider.
- Adds runtime divider reload applied only at period boundaries, so clk_adc never has runt pulses.
- Adds continuous and burst (N-sample) modes, a per-sample strobe, and busy/done status.
- Sits between the control/UI logic and the ADC interface; sample_stb qualifies data capture in the acquisition path.

---
 rtl/adc_clock_gen.sv | 132 +++++++++++++
 1 files changed

// File: rtl/adc_clock_gen.sv
// Programmable ADC sample-clock generator: glitch-free divider reload at period
// boundaries, continuous and N-sample burst modes, per-sample strobe, status.
module adc_clock_gen #(
    parameter int unsigned CNT_W   = 12,
    parameter int unsigned BURST_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic               start,
    input  logic [CNT_W-1:0]   div_half,
    input  logic [BURST_W-1:0] burst_len,
    output logic               clk_adc,
    output logic               sample_stb,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] sample_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               clk_adc_q, clk_adc_d;
    logic               stb_q, stb_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BURST_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic [CNT_W-1:0]   active_half_q, active_half_d;
    logic               run_mode_q, run_mode_d;
    logic [BURST_W-1:0] burst_len_q, burst_len_d;

    logic go_c;
    logic burst_end_c;
    logic stop_c;

    // Start/stop decisions; burst length is frozen at go so mid-run edits are ignored
    always_comb begin
        go_c        = en && (!mode || (start && (burst_len != '0)));
        burst_end_c = run_mode_q && (sample_cnt_q == burst_len_q);
        stop_c      = !en || burst_end_c;
    end

    // Next-state and registered-output logic; strobes default low
    always_comb begin
        state_d       = state_q;
        clk_adc_d     = clk_adc_q;
        stb_d         = 1'b0;
        done_d        = 1'b0;
        sample_cnt_d  = sample_cnt_q;
        counter_d     = counter_q;
        active_half_d = active_half_q;
        run_mode_d    = run_mode_q;
        burst_len_d   = burst_len_q;

        case (state_q)
            IDLE: begin
                clk_adc_d = 1'b0;
                counter_d = '0;
                if (go_c) begin
                    state_d       = RUN;
                    clk_adc_d     = 1'b1;
                    stb_d         = 1'b1;
                    sample_cnt_d  = BURST_W'(1);
                    active_half_d = div_half;
                    run_mode_d    = mode;
                    burst_len_d   = burst_len;
                end
            end
            RUN: begin
                if (counter_q != active_half_q) begin
                    counter_d = counter_q + CNT_W'(1);
                end else begin
                    counter_d = '0;
                    if (clk_adc_q) begin
                        clk_adc_d = 1'b0;
                    end else if (stop_c) begin
                        // Period boundary: finish here, done only on a completed burst
                        state_d = IDLE;
                        done_d  = burst_end_c;
                    end else begin
                        clk_adc_d     = 1'b1;
                        stb_d         = 1'b1;
                        sample_cnt_d  = sample_cnt_q + BURST_W'(1);
                        active_half_d = div_half;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            clk_adc_q     <= 1'b0;
            stb_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            sample_cnt_q  <= '0;
            counter_q     <= '0;
            active_half_q <= '0;
            run_mode_q    <= 1'b0;
            burst_len_q   <= '0;
        end else begin
            state_q       <= state_d;
            clk_adc_q     <= clk_adc_d;
            stb_q         <= stb_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            sample_cnt_q  <= sample_cnt_d;
            counter_q     <= counter_d;
            active_half_q <= active_half_d;
            run_mode_q    <= run_mode_d;
            burst_len_q   <= burst_len_d;
        end
    end

    assign clk_adc    = clk_adc_q;
    assign sample_stb = stb_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sample_cnt = sample_cnt_q;

endmodule
